piezo_sequencer: RTL and testbench

Parametrised successor of the single-channel piezo tone player. Plays one of NUM_TUNES stored melodies on a square-wave speaker output, using a phase accumulator and a fixed note-slot length.
- Adds a start/stop handshake, optional pre-emption of a running tune, and busy/done/reject status.
- Mutes the output cleanly on rest slots.
- Sits between the game controller (event → tune select) and the piezo pin.

---
 rtl/piezo_pkg.sv | 27 ++
 rtl/piezo_tune_rom.sv | 85 ++++++++
 rtl/piezo_sequencer.sv | 167 ++++++++++++++++
 tb/tb_piezo_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// Shared constants and types for the piezo tune sequencer.
package piezo_pkg;

  // Note codes double as phase increments; 0 is a rest.
  typedef logic [6:0] note_t;

  localparam note_t NOTE_REST = 7'd0;
  localparam note_t NOTE_F    = 7'd17;
  localparam note_t NOTE_GS   = 7'd20;
  localparam note_t NOTE_A    = 7'd21;
  localparam note_t NOTE_CH   = 7'd25;
  localparam note_t NOTE_EH   = 7'd31;
  localparam note_t NOTE_FH   = 7'd33;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int TUNE_MARCH = 0;
  localparam int TUNE_EAT   = 1;
  localparam int TUNE_OVER  = 2;
  localparam int TUNE_TEST  = 3;

  localparam int MARCH_LEN  = 102;

endpackage

// File: rtl/piezo_tune_rom.sv
// Combinational tune table: (tune, slot) -> (step, last).
// Anything outside a stored tune reads as a terminating rest.
module piezo_tune_rom
  import piezo_pkg::*;
#(
  parameter int STEP_W = 7,
  parameter int SEL_W  = 2,
  parameter int SLOT_W = 7
) (
  input  logic [SEL_W-1:0]  tune,
  input  logic [SLOT_W-1:0] slot,
  output logic [STEP_W-1:0] step,
  output logic              last
);

  localparam note_t MARCH [0:MARCH_LEN-1] = '{
    NOTE_A,    NOTE_REST, NOTE_A,    NOTE_REST, NOTE_A,    NOTE_REST, NOTE_F,    NOTE_CH,   NOTE_A,    NOTE_REST,
    NOTE_F,    NOTE_CH,   NOTE_A,    NOTE_A,    NOTE_REST, NOTE_REST, NOTE_EH,   NOTE_REST, NOTE_EH,   NOTE_REST,
    NOTE_EH,   NOTE_REST, NOTE_FH,   NOTE_CH,   NOTE_GS,   NOTE_REST, NOTE_F,    NOTE_CH,   NOTE_A,    NOTE_A,
    NOTE_REST, NOTE_REST, NOTE_A,    NOTE_REST, NOTE_A,    NOTE_REST, NOTE_A,    NOTE_REST, NOTE_F,    NOTE_CH,
    NOTE_A,    NOTE_REST, NOTE_F,    NOTE_CH,   NOTE_A,    NOTE_A,    NOTE_REST, NOTE_REST, NOTE_EH,   NOTE_REST,
    NOTE_EH,   NOTE_REST, NOTE_EH,   NOTE_REST, NOTE_FH,   NOTE_CH,   NOTE_GS,   NOTE_REST, NOTE_F,    NOTE_CH,
    NOTE_A,    NOTE_A,    NOTE_REST, NOTE_REST, NOTE_A,    NOTE_A,    NOTE_A,    NOTE_REST, NOTE_F,    NOTE_CH,
    NOTE_A,    NOTE_REST, NOTE_F,    NOTE_CH,   NOTE_A,    NOTE_REST, NOTE_EH,   NOTE_EH,   NOTE_FH,   NOTE_CH,
    NOTE_GS,   NOTE_REST, NOTE_F,    NOTE_CH,   NOTE_A,    NOTE_A,    NOTE_REST, NOTE_REST, NOTE_A,    NOTE_REST,
    NOTE_F,    NOTE_CH,   NOTE_A,    NOTE_REST, NOTE_F,    NOTE_CH,   NOTE_A,    NOTE_A,    NOTE_A,    NOTE_REST,
    NOTE_REST, NOTE_REST
  };

  logic [31:0] tune_i;
  logic [31:0] slot_i;
  note_t       note_s;
  logic        last_s;

  // Decode the stored tunes; default is a rest that ends the tune.
  always_comb begin
    tune_i = 32'(tune);
    slot_i = 32'(slot);
    note_s = NOTE_REST;
    last_s = 1'b1;
    case (tune_i)
      TUNE_MARCH: begin
        if (slot_i < MARCH_LEN) begin
          note_s = MARCH[slot_i[6:0]];
          last_s = (slot_i == 32'(MARCH_LEN - 1));
        end else begin
          note_s = NOTE_REST;
          last_s = 1'b1;
        end
      end
      TUNE_EAT: begin
        case (slot_i)
          32'd0:   begin note_s = NOTE_F;    last_s = 1'b0; end
          32'd1:   begin note_s = NOTE_F;    last_s = 1'b1; end
          default: begin note_s = NOTE_REST; last_s = 1'b1; end
        endcase
      end
      TUNE_OVER: begin
        case (slot_i)
          32'd0, 32'd1, 32'd5, 32'd6: begin note_s = NOTE_F;    last_s = 1'b0; end
          32'd2, 32'd3, 32'd7:        begin note_s = NOTE_A;    last_s = 1'b0; end
          32'd4:                      begin note_s = NOTE_REST; last_s = 1'b0; end
          32'd8:                      begin note_s = NOTE_A;    last_s = 1'b1; end
          default:                    begin note_s = NOTE_REST; last_s = 1'b1; end
        endcase
      end
      TUNE_TEST: begin
        case (slot_i)
          32'd0:   begin note_s = 7'd1;      last_s = 1'b0; end
          32'd1:   begin note_s = NOTE_REST; last_s = 1'b0; end
          32'd2:   begin note_s = 7'd1;      last_s = 1'b1; end
          default: begin note_s = NOTE_REST; last_s = 1'b1; end
        endcase
      end
      default: begin
        note_s = NOTE_REST;
        last_s = 1'b1;
      end
    endcase
  end

  assign step = STEP_W'(note_s);
  assign last = last_s;

endmodule

// File: rtl/piezo_sequencer.sv
// Tune sequencer: start/stop handshake, note-slot timing and a phase
// accumulator whose MSB drives the piezo. Rests mute and freeze phase.
module piezo_sequencer
  import piezo_pkg::*;
#(
  parameter int ACC_W     = 21,
  parameter int STEP_W    = 7,
  parameter int SLOT_LEN  = 2097152,
  parameter int NUM_TUNES = 4,
  parameter int SEL_W     = 2,
  parameter int SLOT_W    = 7,
  parameter int PREEMPT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  tune_sel,
  input  logic              stop,
  output logic              speaker,
  output logic              busy,
  output logic              done,
  output logic              reject,
  output logic [SLOT_W-1:0] slot
);

  localparam int                TICK_W     = $clog2(SLOT_LEN);
  localparam int                SUM_W      = (ACC_W > STEP_W) ? ACC_W : STEP_W;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SLOT_LEN - 1);
  localparam logic              PREEMPT_EN = (PREEMPT != 32'sd0);

  state_t             state_r, state_s;
  logic [ACC_W-1:0]   acc_r, acc_s;
  logic [TICK_W-1:0]  tick_r, tick_s;
  logic [SLOT_W-1:0]  slot_r, slot_s;
  logic [SEL_W-1:0]   tune_r, tune_s;
  logic               speaker_r, speaker_s;
  logic               done_r, done_s;
  logic               reject_r, reject_s;

  logic [STEP_W-1:0]  step_s;
  logic               last_s;
  logic               sel_ok_s;
  logic [SUM_W-1:0]   sum_s;
  logic [ACC_W-1:0]   acc_sum_s;
  logic               slot_end_s;
  logic               slot_max_s;

  piezo_tune_rom #(
    .STEP_W (STEP_W),
    .SEL_W  (SEL_W),
    .SLOT_W (SLOT_W)
  ) u_rom (
    .tune (tune_r),
    .slot (slot_r),
    .step (step_s),
    .last (last_s)
  );

  assign sel_ok_s   = (32'(tune_sel) < 32'(NUM_TUNES));
  assign sum_s      = SUM_W'(acc_r) + SUM_W'(step_s);
  assign acc_sum_s  = sum_s[ACC_W-1:0];
  assign slot_end_s = (tick_r == TICK_LAST);
  assign slot_max_s = (slot_r == {SLOT_W{1'b1}});

  // Next-state and datapath: stop beats start; a valid start (re)launches.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    tick_s    = tick_r;
    slot_s    = slot_r;
    tune_s    = tune_r;
    speaker_s = speaker_r;
    done_s    = 1'b0;
    reject_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (stop) begin
          state_s = IDLE;
        end else if (start && sel_ok_s) begin
          state_s   = PLAY;
          acc_s     = '0;
          tick_s    = '0;
          slot_s    = '0;
          tune_s    = tune_sel;
          speaker_s = 1'b0;
        end else if (start) begin
          reject_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      PLAY: begin
        if (stop) begin
          state_s   = IDLE;
          acc_s     = '0;
          tick_s    = '0;
          slot_s    = '0;
          speaker_s = 1'b0;
        end else if (start && sel_ok_s && PREEMPT_EN) begin
          state_s   = PLAY;
          acc_s     = '0;
          tick_s    = '0;
          slot_s    = '0;
          tune_s    = tune_sel;
          speaker_s = 1'b0;
        end else begin
          // A refused start reports reject and suppresses a coinciding done.
          reject_s  = start;
          acc_s     = acc_sum_s;
          speaker_s = (step_s != '0) ? acc_sum_s[ACC_W-1] : 1'b0;
          if (slot_end_s) begin
            if (last_s || slot_max_s) begin
              state_s   = IDLE;
              acc_s     = '0;
              tick_s    = '0;
              slot_s    = '0;
              speaker_s = 1'b0;
              done_s    = ~start;
            end else begin
              slot_s = slot_r + SLOT_W'(1);
              tick_s = '0;
            end
          end else begin
            tick_s = tick_r + TICK_W'(1);
          end
        end
      end
      default: begin
        state_s   = IDLE;
        acc_s     = '0;
        tick_s    = '0;
        slot_s    = '0;
        speaker_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      acc_r     <= '0;
      tick_r    <= '0;
      slot_r    <= '0;
      tune_r    <= '0;
      speaker_r <= 1'b0;
      done_r    <= 1'b0;
      reject_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      tick_r    <= tick_s;
      slot_r    <= slot_s;
      tune_r    <= tune_s;
      speaker_r <= speaker_s;
      done_r    <= done_s;
      reject_r  <= reject_s;
    end
  end

  assign speaker = speaker_r;
  assign busy    = (state_r == PLAY);
  assign done    = done_r;
  assign reject  = reject_r;
  assign slot    = slot_r;

endmodule

// File: tb/tb_piezo_sequencer.sv
// Directed bench for piezo_sequencer with short slots and a 4-bit accumulator.
// Instance a: PREEMPT=1; b: PREEMPT=0; c: NUM_TUNES=3. Inputs are shared.
module tb_piezo_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] tune_sel;

  logic       spk_a, busy_a, done_a, rej_a;
  logic [6:0] slot_a;
  logic       spk_b, busy_b, done_b, rej_b;
  logic [6:0] slot_b;
  logic       spk_c, busy_c, done_c, rej_c;
  logic [6:0] slot_c;

  int checks = 0;
  int errors = 0;
  int done_cnt;

  piezo_sequencer #(.ACC_W(4), .SLOT_LEN(8), .NUM_TUNES(4), .SEL_W(2), .PREEMPT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .tune_sel(tune_sel), .stop(stop),
    .speaker(spk_a), .busy(busy_a), .done(done_a), .reject(rej_a), .slot(slot_a));

  piezo_sequencer #(.ACC_W(4), .SLOT_LEN(8), .NUM_TUNES(4), .SEL_W(2), .PREEMPT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .tune_sel(tune_sel), .stop(stop),
    .speaker(spk_b), .busy(busy_b), .done(done_b), .reject(rej_b), .slot(slot_b));

  piezo_sequencer #(.ACC_W(4), .SLOT_LEN(8), .NUM_TUNES(3), .SEL_W(2), .PREEMPT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .tune_sel(tune_sel), .stop(stop),
    .speaker(spk_c), .busy(busy_c), .done(done_c), .reject(rej_c), .slot(slot_c));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios, one after another.
  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tune_sel = 2'd0;
    #12;
    chk("rst_spk", spk_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rej", rej_a, 0);
    chk("rst_slot", slot_a, 0);
    rst_n = 1'b1;
    step_clk();

    // Tune 3: step 1, rest, step 1 -- 24 busy cycles.
    start = 1'b1; tune_sel = 2'd3;
    step_clk();
    start = 1'b0;
    chk("s1_busy0", busy_a, 1);
    chk("s1_slot0", slot_a, 0);
    done_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      step_clk();
      done_cnt += int'(done_a);
      chk("s1_busy", busy_a, (k < 24) ? 1 : 0);
      chk("s1_slot", slot_a, (k < 24) ? k / 8 : 0);
      chk("s1_spk", spk_a, ((k == 8) || (k >= 17 && k <= 23)) ? 1 : 0);
      chk("s1_done", done_a, (k == 24) ? 1 : 0);
    end
    step_clk();
    chk("s1_done_clr", done_a, 0);
    chk("s1_done_cnt", done_cnt, 1);

    // Asynchronous reset in the middle of a tune while the speaker is high.
    start = 1'b1; tune_sel = 2'd3;
    step_clk();
    start = 1'b0;
    repeat (8) step_clk();
    chk("mr_spk_pre", spk_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_spk", spk_a, 0);
    chk("mr_busy", busy_a, 0);
    chk("mr_slot", slot_a, 0);
    chk("mr_done", done_a, 0);
    chk("mr_rej", rej_a, 0);
    rst_n = 1'b1;
    step_clk();
    chk("mr_idle", busy_a, 0);

    // Tune 1: F,F (step 17 wraps to 1 in a 4-bit accumulator).
    start = 1'b1; tune_sel = 2'd1;
    step_clk();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step_clk();
      chk("s2_busy", busy_a, (k < 16) ? 1 : 0);
      chk("s2_slot", slot_a, (k < 16) ? k / 8 : 0);
      chk("s2_spk", spk_a, (k >= 8 && k < 16) ? 1 : 0);
      chk("s2_done", done_a, (k == 16) ? 1 : 0);
    end

    // Tune 2: nine slots, slot 4 a rest.
    start = 1'b1; tune_sel = 2'd2;
    step_clk();
    start = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      step_clk();
      chk("s3_busy", busy_a, (k < 72) ? 1 : 0);
      chk("s3_slot", slot_a, (k < 72) ? k / 8 : 0);
      chk("s3_done", done_a, (k == 72) ? 1 : 0);
      if (k >= 33 && k <= 40) chk("s3_rest_spk", spk_a, 0);
      if (k == 8 || k == 18) chk("s3_spk_hi", spk_a, 1);
      if (k == 64) chk("s3_slot8", slot_a, 8);
    end

    // Start tune 1 while tune 2 is at slot 3: a preempts, b rejects.
    start = 1'b1; tune_sel = 2'd2;
    step_clk();
    start = 1'b0;
    for (int k = 1; k <= 26; k++) step_clk();
    chk("s4_slot3", slot_a, 3);
    start = 1'b1; tune_sel = 2'd1;
    step_clk();
    start = 1'b0;
    chk("s4a_busy", busy_a, 1);
    chk("s4a_slot", slot_a, 0);
    chk("s4a_rej", rej_a, 0);
    chk("s4a_done", done_a, 0);
    chk("s4b_rej", rej_b, 1);
    chk("s4b_busy", busy_b, 1);
    chk("s4b_slot", slot_b, 3);
    done_cnt = 0;
    for (int m = 1; m <= 16; m++) begin
      step_clk();
      done_cnt += int'(done_a);
      if (m == 1) chk("s4b_rej_clr", rej_b, 0);
      chk("s4a_busy_run", busy_a, (m < 16) ? 1 : 0);
      if (m == 16) chk("s4a_done_end", done_a, 1);
    end
    chk("s4a_done_cnt", done_cnt, 1);
    for (int k = 44; k <= 72; k++) begin
      step_clk();
      chk("s4b_busy_run", busy_b, (k < 72) ? 1 : 0);
      if (k == 72) chk("s4b_done", done_b, 1);
    end
    step_clk();

    // Stop at slot 1 of tune 3, then start+stop together from idle.
    start = 1'b1; tune_sel = 2'd3;
    step_clk();
    start = 1'b0;
    repeat (9) step_clk();
    chk("s5_slot1", slot_a, 1);
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    chk("s5_busy", busy_a, 0);
    chk("s5_slot", slot_a, 0);
    chk("s5_spk", spk_a, 0);
    chk("s5_done", done_a, 0);
    done_cnt = 0;
    repeat (30) begin
      step_clk();
      done_cnt += int'(done_a);
    end
    chk("s5_no_done", done_cnt, 0);
    start = 1'b1; stop = 1'b1; tune_sel = 2'd1;
    step_clk();
    start = 1'b0; stop = 1'b0;
    chk("s5_ss_busy", busy_a, 0);
    chk("s5_ss_rej", rej_a, 0);
    step_clk();
    chk("s5_ss_busy2", busy_a, 0);

    // Out-of-range tune on the three-tune instance.
    start = 1'b1; tune_sel = 2'd3;
    step_clk();
    start = 1'b0;
    chk("s6_rej", rej_c, 1);
    chk("s6_busy", busy_c, 0);
    step_clk();
    chk("s6_rej_clr", rej_c, 0);
    chk("s6_busy2", busy_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
